// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART receive and transmit sides.
//   - default bit period in clk cycles
//   - parity sense encoding
//   - receive FSM state encoding
package uart_pkg;

    localparam int unsigned DefaultClksPerBit = 16;

    // Parity sense
    localparam int unsigned ParEven = 0;
    localparam int unsigned ParOdd  = 1;

    // Receive FSM states
    localparam logic [2:0] RxIdle     = 3'd0;
    localparam logic [2:0] RxStart    = 3'd1;
    localparam logic [2:0] RxData     = 3'd2;
    localparam logic [2:0] RxParity   = 3'd3;
    localparam logic [2:0] RxStop     = 3'd4;
    localparam logic [2:0] RxWaitIdle = 3'd5;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for the asynchronous serial line, plus falling-edge detect.
// Every flop resets to 1 so that an idle line produces no edge when reset is released.
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   rx_i    raw serial line, asynchronous to clk_i
//   rx_s_o  synchronised line
//   fall_o  high for one cycle when rx_s_o goes from 1 to 0
module uart_rx_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rx_i,
    output logic rx_s_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rx_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rx_s_o = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive controller.
// Detects a start bit, samples each bit mid-period, shifts data in LSB-first, checks the stop bit
// and presents each completed byte through a single-entry valid/ready buffer.
// Optional feature macro: UART_RX_PARITY_EN adds a parity bit between data and stop.
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   rx_i           serial line, idle high, asynchronous
//   rx_data_o      received byte, stable while rx_valid_o is high
//   rx_valid_o     byte available, held until accepted
//   rx_ready_i     consumer accepts when rx_valid_o && rx_ready_i at a clock edge
//   frame_err_o    1-cycle pulse: stop bit sampled 0
//   parity_err_o   1-cycle pulse: parity mismatch (always 0 without the macro)
//   overrun_err_o  1-cycle pulse: frame completed while the buffer was full
//   busy_o         high whenever the FSM is not idle
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_ODD   = ParEven
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 overrun_err_o,
    output logic                 busy_o
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IdxW = $clog2(DATA_BITS);

    localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

    logic rx_s;
    logic rx_fall;

    uart_rx_sync u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .rx_i   (rx_i),
        .rx_s_o (rx_s),
        .fall_o (rx_fall)
    );

    logic [2:0]           state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 frame_ok;
    logic                 parity_bad;

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    logic parity_err_q, parity_err_d;

    // Data ones plus the parity bit must have the configured sense.
    assign parity_bad   = ((^shift_q) ^ par_q) != 1'(PARITY_ODD);
    assign parity_err_o = parity_err_q;
`else
    logic unused_parity_odd;

    assign unused_parity_odd = 1'(PARITY_ODD);
    assign parity_bad        = 1'b0;
    assign parity_err_o      = 1'b0;
`endif

    wire full_period = (cnt_q == CntLast);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        frame_ok    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif

        case (state_q)
            RxIdle: begin
                if (rx_fall) begin
                    state_d = RxStart;
                    cnt_d   = '0;
                end
            end
            RxStart: begin
                if (cnt_q == CntHalf) begin
                    // Counter wraps here so every later sample lands mid-bit.
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? RxIdle : RxData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RxData: begin
                if (full_period) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (idx_q == IdxLast) begin
`ifdef UART_RX_PARITY_EN
                        state_d = RxParity;
`else
                        state_d = RxStop;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            RxParity: begin
                if (full_period) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = RxStop;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            RxStop: begin
                if (full_period) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        frame_err_d = 1'b1;
                        state_d     = RxWaitIdle;
                    end else if (parity_bad) begin
`ifdef UART_RX_PARITY_EN
                        parity_err_d = 1'b1;
`endif
                        state_d = RxIdle;
                    end else begin
                        frame_ok = 1'b1;
                        state_d  = RxIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RxWaitIdle: begin
                // A stuck-low line must return high before a new start bit counts.
                if (rx_s) begin
                    state_d = RxIdle;
                end
            end
            default: begin
                state_d = RxIdle;
            end
        endcase

        // Output buffer: a handshake in the completion cycle frees the slot for the new byte.
        if (frame_ok) begin
            if (valid_q && !rx_ready_i) begin
                overrun_d = 1'b1;
            end else begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end
        end else if (valid_q && rx_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RxIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_data_o     = data_q;
    assign rx_valid_o    = valid_q;
    assign frame_err_o   = frame_err_q;
    assign overrun_err_o = overrun_q;
    assign busy_o        = (state_q != RxIdle);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl with CLKS_PER_BIT=16, DATA_BITS=8.
// Delivered bytes are checked against a queue of expected bytes; pulses are counted by a monitor.
module tb_uart_rx_ctrl;

    localparam int   CPB     = 16;
    localparam logic PAR_ODD = 1'b0;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_EXTRA = CPB;
`else
    localparam int PAR_EXTRA = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_in;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       overrun_err;
    logic       busy;

    uart_rx_ctrl #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .PARITY_ODD   (0)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .rx_i          (rx_in),
        .rx_data_o     (rx_data),
        .rx_valid_o    (rx_valid),
        .rx_ready_i    (rx_ready),
        .frame_err_o   (frame_err),
        .parity_err_o  (parity_err),
        .overrun_err_o (overrun_err),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_rise   = 0;
    int n_deliv  = 0;
    int n_ferr   = 0;
    int n_perr   = 0;
    int n_ovr    = 0;
    int rise_cyc = 0;
    logic prev_valid = 1'b0;
    logic [7:0] sb_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_flip);
        logic par;
        par   = (^data) ^ PAR_ODD ^ par_flip;
        rx_in = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_in = data[i];
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx_in = par;
        tick(CPB);
`endif
        rx_in = stop_bit;
        tick(CPB);
    endtask

    // Output monitor: pops the scoreboard on every handshake, counts pulses and valid rises.
    always @(negedge clk) begin
        logic [7:0] exp;
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (rx_valid && !prev_valid) begin
                n_rise++;
                rise_cyc = cyc;
            end
            prev_valid = rx_valid;
            if (frame_err)   n_ferr++;
            if (parity_err)  n_perr++;
            if (overrun_err) n_ovr++;
            if (rx_valid && rx_ready) begin
                exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
                check("sb_data", {24'd0, rx_data}, {24'd0, exp});
                n_deliv++;
            end
        end
    end

    initial begin
        int t0;
        rst_n    = 1'b0;
        rx_in    = 1'b1;
        rx_ready = 1'b0;
        tick(3);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_data", {24'd0, rx_data}, 32'd0);
        check("rst_errs", {29'd0, frame_err, parity_err, overrun_err}, 32'd0);
        rst_n = 1'b1;
        tick(5);

        // 1: single byte with the consumer ready; check data and latency
        rx_ready = 1'b1;
        sb_q.push_back(8'hA5);
        t0 = cyc;
        send_frame(8'hA5, 1'b1, 1'b0);
        tick(4);
        check("t1_deliv", n_deliv, 1);
        check("t1_rise", n_rise, 1);
        check("t1_latency", rise_cyc, t0 + 1 + 2 + 8 + CPB * 9 + PAR_EXTRA);
        check("t1_errs", n_ferr + n_perr + n_ovr, 0);
        check("t1_valid_cleared", {31'd0, rx_valid}, 32'd0);
        tick(10);

        // 2: short low glitch is rejected
        rx_in = 1'b0;
        tick(3);
        check("t2_busy_start", {31'd0, busy}, 32'd1);
        rx_in = 1'b1;
        tick(10);
        check("t2_busy_idle", {31'd0, busy}, 32'd0);
        check("t2_rise", n_rise, 1);
        check("t2_errs", n_ferr + n_perr + n_ovr, 0);
        tick(10);

        // 3: stop bit 0, line stays low
        send_frame(8'h3C, 1'b0, 1'b0);
        tick(24);
        check("t3_ferr", n_ferr, 1);
        check("t3_busy_low", {31'd0, busy}, 32'd1);
        check("t3_rise", n_rise, 1);
        rx_in = 1'b1;
        tick(5);
        check("t3_busy_idle", {31'd0, busy}, 32'd0);
        tick(10);

        // 4: two frames back-to-back with the consumer stalled
        rx_ready = 1'b0;
        sb_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        tick(4);
        check("t4_ovr", n_ovr, 1);
        check("t4_valid_held", {31'd0, rx_valid}, 32'd1);
        check("t4_data_held", {24'd0, rx_data}, 32'h11);
        check("t4_rise", n_rise, 2);
        rx_ready = 1'b1;
        tick(3);
        check("t4_deliv", n_deliv, 2);
        check("t4_valid_cleared", {31'd0, rx_valid}, 32'd0);
        tick(10);

        // 5: reset in the middle of a frame, then a clean frame
        rx_in = 1'b0;
        tick(CPB);
        rx_in = 1'b1;
        tick(3 * CPB);
        check("t5_busy_pre", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_data", {24'd0, rx_data}, 32'd0);
        check("t5_rst_valid", {31'd0, rx_valid}, 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(5 * CPB);
        check("t5_no_restart", {31'd0, busy}, 32'd0);
        sb_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0);
        tick(4);
        check("t5_deliv", n_deliv, 3);
        check("t5_rise", n_rise, 3);
        tick(10);

`ifdef UART_RX_PARITY_EN
        // 6: wrong then correct parity
        send_frame(8'h07, 1'b1, 1'b1);
        tick(4);
        check("t6_perr", n_perr, 1);
        check("t6_no_rise", n_rise, 3);
        sb_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b0);
        tick(4);
        check("t6_deliv", n_deliv, 4);
        check("t6_perr_once", n_perr, 1);
        tick(10);
`endif

        check("ferr_total", n_ferr, 1);
        check("ovr_total", n_ovr, 1);
        check("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
